// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga core.
// Data cache miss-handling states.
package tartaruga_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_WAIT,
    FILL_REQ,
    FILL_WAIT
  } dcache_state_t;

endpackage

// File: rtl/dcache_way_select.sv
// Way hit detection and miss victim choice for one cache set.
// Victim: lowest-index invalid way, otherwise the round-robin pointer.
module dcache_way_select
  import tartaruga_pkg::*;
#(
  parameter int NUM_WAYS = 2,
  parameter int TAG_BITS = 24,
  parameter int WAY_BITS = 1
) (
  input  logic [NUM_WAYS-1:0]               valid,
  input  logic [NUM_WAYS-1:0][TAG_BITS-1:0] tags,
  input  logic [TAG_BITS-1:0]               tag,
  input  logic [WAY_BITS-1:0]               rr_ptr,
  output logic [NUM_WAYS-1:0]               hit_vec,
  output logic                              hit,
  output logic [WAY_BITS-1:0]               hit_way,
  output logic [WAY_BITS-1:0]               victim
);

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    victim  = rr_ptr;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_vec[w] = valid[w] && (tags[w] == tag);
    end
    // Descending scan so the lowest index wins.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_BITS'(w);
      if (!valid[w]) victim = WAY_BITS'(w);
    end
    hit = |hit_vec;
  end

endmodule

// File: rtl/dcache_wb_assoc.sv
// Set-associative write-back write-allocate L1 data cache.
// Zero-latency hits in IDLE; misses evict dirty victims, then fill.
module dcache_wb_assoc
  import tartaruga_pkg::*;
#(
  parameter int NUM_SETS       = 16,
  parameter int NUM_WAYS       = 2,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          valid_i,
  input  logic [31:0]                   addr_i,
  input  logic                          we_i,
  input  logic [3:0]                    be_i,
  input  logic [31:0]                   data_wr_i,
  output logic [31:0]                   data_rd_o,
  output logic                          ready_o,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic                          mem_we_o,
  output logic [31:0]                   mem_addr_o,
  output logic [32*WORDS_PER_LINE-1:0]  mem_data_wr_o,
  input  logic                          mem_rsp_valid_i,
  output logic                          mem_rsp_ready_o,
  input  logic [31:0]                   mem_rsp_addr_i,
  input  logic [32*WORDS_PER_LINE-1:0]  mem_data_line_i
);

  localparam int LINE_BITS = 32 * WORDS_PER_LINE;
  localparam int WSEL_BITS = $clog2(WORDS_PER_LINE);
  localparam int OFF_BITS  = 2 + WSEL_BITS;
  localparam int IDX_BITS  = $clog2(NUM_SETS);
  localparam int TAG_BITS  = 32 - IDX_BITS - OFF_BITS;
  localparam int WAY_BITS  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [TAG_BITS-1:0] tag;
  } meta_t;

  meta_t               meta_q [NUM_SETS][NUM_WAYS];
  logic [LINE_BITS-1:0] data_q [NUM_SETS][NUM_WAYS];
  logic [WAY_BITS-1:0] rr_q   [NUM_SETS];

  dcache_state_t       state_q, state_d;
  logic [31-OFF_BITS:0] miss_line_q;
  logic [WAY_BITS-1:0] victim_q;

  logic [IDX_BITS-1:0]  idx, m_idx;
  logic [TAG_BITS-1:0]  tag_in, m_tag;
  logic [WSEL_BITS-1:0] wsel;
  logic [NUM_WAYS-1:0]  set_valid, hit_vec;
  logic [NUM_WAYS-1:0][TAG_BITS-1:0] set_tags;
  logic                 hit;
  logic [WAY_BITS-1:0]  hit_way, victim, rr_next;
  logic [LINE_BITS-1:0] hit_line, merged, vic_line;
  logic [31:0]          rd_word, wb_addr, fill_addr;
  meta_t                vic_meta, new_vic;
  logic                 miss_start, store_hit, fill_done;

  assign idx    = addr_i[OFF_BITS +: IDX_BITS];
  assign tag_in = addr_i[31 -: TAG_BITS];
  assign wsel   = addr_i[OFF_BITS-1:2];
  assign m_idx  = miss_line_q[IDX_BITS-1:0];
  assign m_tag  = miss_line_q[31-OFF_BITS -: TAG_BITS];

  always_comb begin
    set_valid = '0;
    set_tags  = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      set_valid[w] = meta_q[idx][w].valid;
      set_tags[w]  = meta_q[idx][w].tag;
    end
  end

  dcache_way_select #(
    .NUM_WAYS(NUM_WAYS),
    .TAG_BITS(TAG_BITS),
    .WAY_BITS(WAY_BITS)
  ) u_way_select (
    .valid  (set_valid),
    .tags   (set_tags),
    .tag    (tag_in),
    .rr_ptr (rr_q[idx]),
    .hit_vec(hit_vec),
    .hit    (hit),
    .hit_way(hit_way),
    .victim (victim)
  );

  assign hit_line  = data_q[idx][hit_way];
  assign rd_word   = hit_line[32*int'(wsel) +: 32];
  assign new_vic   = meta_q[idx][victim];
  assign vic_meta  = meta_q[m_idx][victim_q];
  assign vic_line  = data_q[m_idx][victim_q];
  assign wb_addr   = {vic_meta.tag, m_idx, {OFF_BITS{1'b0}}};
  assign fill_addr = {miss_line_q, {OFF_BITS{1'b0}}};
  assign rr_next   = (victim_q == WAY_BITS'(NUM_WAYS - 1))
                   ? '0 : victim_q + 1'b1;

  always_comb begin
    merged = hit_line;
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) merged[32*int'(wsel) + 8*b +: 8] = data_wr_i[8*b +: 8];
    end
  end

  always_comb begin
    state_d         = state_q;
    ready_o         = 1'b0;
    data_rd_o       = '0;
    mem_req_valid_o = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;
    mem_data_wr_o   = '0;
    mem_rsp_ready_o = 1'b0;
    miss_start      = 1'b0;
    store_hit       = 1'b0;
    fill_done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_o = !valid_i || hit;
        if (valid_i && hit && !we_i) data_rd_o = rd_word;
        store_hit = valid_i && hit && we_i && (|be_i);
        if (valid_i && !hit) begin
          miss_start = 1'b1;
          state_d = (new_vic.valid && new_vic.dirty) ? WB_REQ : FILL_REQ;
        end
      end
      WB_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_we_o        = 1'b1;
        mem_addr_o      = wb_addr;
        mem_data_wr_o   = vic_line;
        if (mem_req_ready_i) state_d = WB_WAIT;
      end
      WB_WAIT: begin
        mem_rsp_ready_o = 1'b1;
        if (mem_rsp_valid_i && mem_rsp_addr_i == wb_addr) state_d = FILL_REQ;
      end
      FILL_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = fill_addr;
        if (mem_req_ready_i) state_d = FILL_WAIT;
      end
      FILL_WAIT: begin
        mem_rsp_ready_o = 1'b1;
        if (mem_rsp_valid_i && mem_rsp_addr_i == fill_addr) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      miss_line_q <= '0;
      victim_q    <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) meta_q[s][w] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        miss_line_q <= addr_i[31:OFF_BITS];
        victim_q    <= victim;
      end
      if (store_hit) meta_q[idx][hit_way].dirty <= 1'b1;
      if (fill_done) begin
        meta_q[m_idx][victim_q] <= {1'b1, 1'b0, m_tag};
        rr_q[m_idx]             <= rr_next;
      end
    end
  end

  // Line storage has no reset; valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (store_hit) data_q[idx][hit_way] <= merged;
    if (fill_done) data_q[m_idx][victim_q] <= mem_data_line_i;
  end

  a_onehot_hit: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (state_q == IDLE && valid_i) |-> $onehot0(hit_vec));

  a_addr_stable: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (valid_i && !ready_o) |=> (!valid_i || $stable(addr_i)));

endmodule

// File: tb/tb_dcache_wb_assoc.sv
// Self-checking bench for dcache_wb_assoc: directed scenarios plus
// randomized traffic against a flat word-memory reference.
module tb_dcache_wb_assoc;

  logic         clk_i = 1'b0;
  logic         rstn_i = 1'b0;
  logic         valid_i = 1'b0;
  logic [31:0]  addr_i = '0;
  logic         we_i = 1'b0;
  logic [3:0]   be_i = '0;
  logic [31:0]  data_wr_i = '0;
  logic [31:0]  data_rd_o;
  logic         ready_o;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i = 1'b0;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_data_wr_o;
  logic         mem_rsp_valid_i = 1'b0;
  logic         mem_rsp_ready_o;
  logic [31:0]  mem_rsp_addr_i = '0;
  logic [127:0] mem_data_line_i = '0;

  always #5 clk_i = ~clk_i;

  dcache_wb_assoc dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .valid_i        (valid_i),
    .addr_i         (addr_i),
    .we_i           (we_i),
    .be_i           (be_i),
    .data_wr_i      (data_wr_i),
    .data_rd_o      (data_rd_o),
    .ready_o        (ready_o),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_wr_o  (mem_data_wr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_ready_o(mem_rsp_ready_o),
    .mem_rsp_addr_i (mem_rsp_addr_i),
    .mem_data_line_i(mem_data_line_i)
  );

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] data;
  } req_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  req_t log_q [$];
  bit   auto_mem = 1'b1;
  bit   rsp_pend = 1'b0;
  int   rsp_dly = 0;
  int   req_dly = 0;
  logic [31:0] rsp_addr = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : a;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : a;
  endfunction

  function automatic logic [127:0] build_line(input logic [31:0] a);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = mem_rd(a + 32'(4*i));
    return l;
  endfunction

  // One cycle of the memory responder, called at negedge+1.
  task automatic mem_step();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    if (rsp_pend) begin
      if (rsp_dly != 0) rsp_dly--;
      else begin
        mem_rsp_valid_i = 1'b1;
        mem_rsp_addr_i  = rsp_addr;
        mem_data_line_i = build_line(rsp_addr);
        rsp_pend = 1'b0;
        checks++;
        if (mem_rsp_ready_o !== 1'b1) begin
          errors++;
          $display("FAIL rsp_ready: got %b want 1", mem_rsp_ready_o);
        end
      end
    end else if (mem_req_valid_o === 1'b1) begin
      if (req_dly != 0) req_dly--;
      else begin
        mem_req_ready_i = 1'b1;
        log_q.push_back('{mem_we_o, mem_addr_o, mem_data_wr_o});
        if (mem_we_o)
          for (int i = 0; i < 4; i++)
            bmem[mem_addr_o + 32'(4*i)] = mem_data_wr_o[32*i +: 32];
        rsp_pend = 1'b1;
        rsp_addr = mem_addr_o;
        rsp_dly  = $urandom_range(0, 2);
        req_dly  = $urandom_range(0, 2);
      end
    end
  endtask

  task automatic access(input logic we, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] d,
                        output logic [31:0] rd, output int cyc);
    @(negedge clk_i);
    valid_i = 1'b1; we_i = we; addr_i = a; be_i = be; data_wr_i = d;
    cyc = 0;
    #1;
    while (!ready_o && cyc < 300) begin
      @(negedge clk_i); #1;
      if (auto_mem) mem_step();
      cyc++;
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL access_timeout: addr %h ready %b want 1", a, ready_o);
    end
    rd = data_rd_o;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if ({mem_req_valid_o, mem_we_o, mem_rsp_ready_o, mem_addr_o,
         data_rd_o, mem_data_wr_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req %b we %b addr %h rd %h want 0",
               mem_req_valid_o, mem_we_o, mem_addr_o, data_rd_o);
    end
    rstn_i = 1'b1;
    @(negedge clk_i); #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", ready_o);
    end
  endtask

  task automatic test_cold_load();
    logic [31:0] rd; int cyc; int n0;
    bmem[32'h1000] = 1; bmem[32'h1004] = 2;
    bmem[32'h1008] = 3; bmem[32'h100C] = 4;
    n0 = log_q.size();
    access(0, 32'h1004, 4'h0, 0, rd, cyc);
    checks++;
    if (rd !== 32'd2) begin
      errors++; $display("FAIL cold_load_data: got %h want 2", rd);
    end
    checks++;
    if (log_q.size() != n0 + 1) begin
      errors++;
      $display("FAIL cold_load_reqs: got %0d want 1", log_q.size() - n0);
    end else begin
      checks++;
      if ({log_q[n0].we, log_q[n0].addr} !== {1'b0, 32'h1000}) begin
        errors++;
        $display("FAIL cold_fill_req: we %b addr %h want 0 00001000",
                 log_q[n0].we, log_q[n0].addr);
      end
    end
  endtask

  task automatic test_store_hit();
    logic [31:0] rd; int cyc; int n0;
    n0 = log_q.size();
    access(1, 32'h1008, 4'b0011, 32'hDEADBEEF, rd, cyc);
    checks++;
    if (cyc != 0 || log_q.size() != n0) begin
      errors++;
      $display("FAIL store_hit_lat: cyc %0d reqs %0d want 0 0",
               cyc, log_q.size() - n0);
    end
    access(0, 32'h1008, 4'h0, 0, rd, cyc);
    checks++;
    if (rd !== 32'h0000BEEF || cyc != 0) begin
      errors++;
      $display("FAIL store_merge: got %h cyc %0d want 0000beef 0", rd, cyc);
    end
    access(1, 32'h100C, 4'h0, 32'hFFFFFFFF, rd, cyc);
    access(0, 32'h100C, 4'h0, 0, rd, cyc);
    checks++;
    if (rd !== 32'd4 || cyc != 0) begin
      errors++;
      $display("FAIL store_be0: got %h cyc %0d want 4 0", rd, cyc);
    end
  endtask

  task automatic test_second_way();
    logic [31:0] rd; int cyc; int n0;
    n0 = log_q.size();
    access(0, 32'h2000, 4'h0, 0, rd, cyc);
    checks++;
    if (rd !== 32'h2000 || log_q.size() != n0 + 1 ||
        log_q[log_q.size()-1].we !== 1'b0) begin
      errors++;
      $display("FAIL way1_fill: got %h reqs %0d want 2000 1",
               rd, log_q.size() - n0);
    end
    access(0, 32'h1004, 4'h0, 0, rd, cyc);
    checks++;
    if (rd !== 32'd2 || cyc != 0) begin
      errors++;
      $display("FAIL way0_keep: got %h cyc %0d want 2 0", rd, cyc);
    end
  endtask

  task automatic test_evict();
    logic [31:0] rd; int cyc; int n0;
    n0 = log_q.size();
    access(0, 32'h3000, 4'h0, 0, rd, cyc);
    checks++;
    if (rd !== 32'h3000) begin
      errors++; $display("FAIL evict_data: got %h want 3000", rd);
    end
    checks++;
    if (log_q.size() != n0 + 2) begin
      errors++;
      $display("FAIL evict_reqs: got %0d want 2", log_q.size() - n0);
    end else begin
      checks++;
      if ({log_q[n0].we, log_q[n0].addr} !== {1'b1, 32'h1000} ||
          log_q[n0].data !== {32'd4, 32'h0000BEEF, 32'd2, 32'd1}) begin
        errors++;
        $display("FAIL evict_wb: we %b addr %h data %h want 1 1000 %h",
                 log_q[n0].we, log_q[n0].addr, log_q[n0].data,
                 {32'd4, 32'h0000BEEF, 32'd2, 32'd1});
      end
      checks++;
      if ({log_q[n0+1].we, log_q[n0+1].addr} !== {1'b0, 32'h3000}) begin
        errors++;
        $display("FAIL evict_fill: we %b addr %h want 0 3000",
                 log_q[n0+1].we, log_q[n0+1].addr);
      end
    end
    access(0, 32'h2000, 4'h0, 0, rd, cyc);
    checks++;
    if (rd !== 32'h2000 || cyc != 0) begin
      errors++;
      $display("FAIL evict_keep: got %h cyc %0d want 2000 0", rd, cyc);
    end
  endtask

  task automatic test_backpressure();
    int n;
    auto_mem = 1'b0;
    @(negedge clk_i);
    valid_i = 1'b1; we_i = 1'b0; addr_i = 32'h5010; be_i = 4'h0;
    #1;
    n = 0;
    while (mem_req_valid_o !== 1'b1 && n < 20) begin
      @(negedge clk_i); #1; n++;
    end
    checks++;
    if ({mem_req_valid_o, mem_we_o, mem_addr_o} !== {2'b10, 32'h5010}) begin
      errors++;
      $display("FAIL bp_req: valid %b we %b addr %h want 1 0 5010",
               mem_req_valid_o, mem_we_o, mem_addr_o);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); #1;
      checks++;
      if (mem_req_valid_o !== 1'b1 || mem_addr_o !== 32'h5010) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d valid %b addr %h want 1 5010",
                 i, mem_req_valid_o, mem_addr_o);
      end
    end
    mem_req_ready_i = 1'b1;
    @(negedge clk_i); #1;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_addr_i  = 32'h5110;
    mem_data_line_i = {4{32'hBAD0BAD0}};
    @(negedge clk_i); #1;
    mem_rsp_valid_i = 1'b0;
    checks++;
    if (mem_rsp_ready_o !== 1'b1 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_bad_rsp: rsp_ready %b ready %b want 1 0",
               mem_rsp_ready_o, ready_o);
    end
    mem_rsp_valid_i = 1'b1;
    mem_rsp_addr_i  = 32'h5010;
    mem_data_line_i = build_line(32'h5010);
    @(negedge clk_i); #1;
    mem_rsp_valid_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || data_rd_o !== 32'h5010) begin
      errors++;
      $display("FAIL bp_complete: ready %b rd %h want 1 5010",
               ready_o, data_rd_o);
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    auto_mem = 1'b1;
  endtask

  task automatic test_reset_mid_miss();
    logic [31:0] rd; int cyc; int n0; int n;
    auto_mem = 1'b0;
    @(negedge clk_i);
    valid_i = 1'b1; we_i = 1'b0; addr_i = 32'h7000; be_i = 4'h0;
    #1;
    n = 0;
    while (mem_req_valid_o !== 1'b1 && n < 20) begin
      @(negedge clk_i); #1; n++;
    end
    mem_req_ready_i = 1'b1;
    @(negedge clk_i); #1;
    mem_req_ready_i = 1'b0;
    checks++;
    if (mem_rsp_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_fill_wait: rsp_ready %b want 1", mem_rsp_ready_o);
    end
    rstn_i = 1'b0;
    #1;
    checks++;
    if ({mem_req_valid_o, mem_we_o, mem_rsp_ready_o, mem_addr_o,
         data_rd_o, mem_data_wr_o} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: req %b rsp_rdy %b addr %h want 0",
               mem_req_valid_o, mem_rsp_ready_o, mem_addr_o);
    end
    valid_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL rst_mid_ready: got %b want 1", ready_o);
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    rsp_pend = 1'b0; req_dly = 0;
    auto_mem = 1'b1;
    n0 = log_q.size();
    access(0, 32'h1004, 4'h0, 0, rd, cyc);
    checks++;
    if (rd !== 32'd2 || cyc == 0 || log_q.size() != n0 + 1 ||
        log_q[log_q.size()-1].addr !== 32'h1000) begin
      errors++;
      $display("FAIL rst_refill: rd %h cyc %0d reqs %0d want 2 >0 1",
               rd, cyc, log_q.size() - n0);
    end
    access(0, 32'h3000, 4'h0, 0, rd, cyc);
    checks++;
    if (rd !== 32'h3000 || cyc == 0) begin
      errors++;
      $display("FAIL rst_invalidate: rd %h cyc %0d want 3000 >0", rd, cyc);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, wa, d, rd, w;
    logic [3:0] be;
    logic we;
    int cyc, n0, k;
    ref_mem = bmem;
    for (int t = 0; t < 400; t++) begin
      a = 32'h10000 + (32'($urandom_range(0, 5)) << 12)
        + (32'($urandom_range(0, 3)) << 4)
        + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
      wa = {a[31:2], 2'b00};
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom);
      d  = $urandom;
      n0 = log_q.size();
      access(we, a, be, d, rd, cyc);
      k = log_q.size() - n0;
      checks++;
      if (k > 2 || (k == 0) != (cyc == 0) || (k > 0 &&
          {log_q[n0+k-1].we, log_q[n0+k-1].addr} !== {1'b0, a & ~32'hF}) ||
          (k == 2 && log_q[n0].we !== 1'b1)) begin
        errors++;
        $display("FAIL rnd_traffic: t %0d addr %h reqs %0d cyc %0d",
                 t, a, k, cyc);
      end
      if (k == 2) begin
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (log_q[n0].data[32*i +: 32] !==
              ref_rd(log_q[n0].addr + 32'(4*i))) begin
            errors++;
            $display("FAIL rnd_wb_data: addr %h got %h want %h",
                     log_q[n0].addr + 32'(4*i), log_q[n0].data[32*i +: 32],
                     ref_rd(log_q[n0].addr + 32'(4*i)));
          end
        end
      end
      if (!we) begin
        checks++;
        if (rd !== ref_rd(wa)) begin
          errors++;
          $display("FAIL rnd_load: addr %h got %h want %h", wa, rd, ref_rd(wa));
        end
      end else begin
        w = ref_rd(wa);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[wa] = w;
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_hit();
    test_second_way();
    test_evict();
    test_backpressure();
    test_reset_mid_miss();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
